// File: rtl/riscv_pkg.sv
// Shared opcode constants, FSM state encoding and control-field enums for the
// multicycle controller.
package riscv_pkg;

   localparam int ACK_TIMEOUT_DEF = 16;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   typedef enum logic {
      PC_PLUS4  = 1'b0,
      PC_TARGET = 1'b1
   } pc_sel_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   function automatic logic is_legal(input logic [6:0] op);
      return op inside {OP_IMM, OP_LOAD, OP_STORE, OP_LUI, OP_BRANCH, OP_JAL};
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-ack watchdog: down-counter reloaded whenever a request is not waiting;
// o_expired flags the LIMIT-th consecutive unacknowledged request cycle.
module mc_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_wait,
   output logic o_expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= W'(LIMIT - 1);
      end else if (i_wait) begin
         if (cnt != '0) cnt <= cnt - W'(1);
      end else begin
         cnt <= W'(LIMIT - 1);
      end
   end

   assign o_expired = i_wait && (cnt == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM. Define MULTICYCLE_CTRL_TRAP_EN to add the
// sticky TRAP state (illegal opcode or ACK_TIMEOUT ack wait); otherwise waits are unbounded.
//
//   state  | meaning
//   FETCH  | request instruction at PC; IR and PC+4 written on ack
//   DECODE | classify opcode; unknown opcodes retire as NOP (or trap)
//   EXEC   | ALU setup, branch/jal PC update
//   MEM    | data request at ALU address, held until ack
//   WB     | single-cycle register write
//   TRAP   | sticky fault until reset (trap build only)
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_instruction,
   input  logic        i_zero,
   input  logic        i_mem_ack,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic        o_addr_sel,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic        o_reg_we,
   output logic        o_pc_sel,
   output logic        o_alu_src,
   output logic [1:0]  o_alu_op,
   output logic [1:0]  o_wb_sel,
   output logic [2:0]  o_state,
   output logic        o_fault
);

   state_e     state, state_nxt;
   logic [6:0] opcode;
   logic       unused_instr;

   assign opcode       = i_instruction[6:0];
   assign unused_instr = ^i_instruction[31:7];
   assign o_state      = state;

`ifdef MULTICYCLE_CTRL_TRAP_EN
   logic req_wait;
   logic timeout;

   assign req_wait = i_rst_n && ((state == FETCH) || (state == MEM)) && !i_mem_ack;

   mc_wait_timer #(.LIMIT(ACK_TIMEOUT)) u_wait_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wait    (req_wait),
      .o_expired (timeout)
   );
`else
   localparam int unused_ack_timeout = ACK_TIMEOUT;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= FETCH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      o_mem_req  = 1'b0;
      o_mem_we   = 1'b0;
      o_addr_sel = 1'b0;
      o_ir_we    = 1'b0;
      o_pc_we    = 1'b0;
      o_reg_we   = 1'b0;
      o_pc_sel   = PC_PLUS4;
      o_alu_src  = 1'b0;
      o_alu_op   = ALU_ADD;
      o_wb_sel   = WB_ALU;
      o_fault    = 1'b0;
      case (state)
         FETCH: begin
            o_mem_req = 1'b1;
            if (i_mem_ack) begin
               o_ir_we   = 1'b1;
               o_pc_we   = 1'b1;
               state_nxt = DECODE;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            else if (timeout) state_nxt = TRAP;
`endif
         end
         DECODE: begin
            if (is_legal(opcode)) state_nxt = EXEC;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            else                  state_nxt = TRAP;
`else
            else                  state_nxt = FETCH;
`endif
         end
         EXEC: begin
            state_nxt = FETCH;
            case (opcode)
               OP_IMM: begin
                  o_alu_src = 1'b1;
                  o_alu_op  = ALU_FUNCT;
                  state_nxt = WB;
               end
               OP_LOAD, OP_STORE: begin
                  o_alu_src = 1'b1;
                  state_nxt = MEM;
               end
               OP_LUI: state_nxt = WB;
               OP_BRANCH: begin
                  o_alu_op = ALU_SUB;
                  if (i_zero) begin
                     o_pc_we  = 1'b1;
                     o_pc_sel = PC_TARGET;
                  end
               end
               OP_JAL: begin
                  o_pc_we  = 1'b1;
                  o_pc_sel = PC_TARGET;
                  o_reg_we = 1'b1;
                  o_wb_sel = WB_PC4;
               end
               default: ;
            endcase
         end
         MEM: begin
            o_mem_req  = 1'b1;
            o_addr_sel = 1'b1;
            o_mem_we   = (opcode == OP_STORE);
            if (i_mem_ack) state_nxt = (opcode == OP_LOAD) ? WB : FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            else if (timeout) state_nxt = TRAP;
`endif
         end
         WB: begin
            o_reg_we  = 1'b1;
            state_nxt = FETCH;
            case (opcode)
               OP_LOAD: o_wb_sel = WB_MEM;
               OP_LUI:  o_wb_sel = WB_IMM;
               default: o_wb_sel = WB_ALU;
            endcase
         end
`ifdef MULTICYCLE_CTRL_TRAP_EN
         TRAP: o_fault = 1'b1;
`endif
         default: state_nxt = FETCH;
      endcase
      // Reset abandons the instruction at once, so no request or write leaks out while it is low.
      if (!i_rst_n) begin
         state_nxt  = FETCH;
         o_mem_req  = 1'b0;
         o_mem_we   = 1'b0;
         o_addr_sel = 1'b0;
         o_ir_we    = 1'b0;
         o_pc_we    = 1'b0;
         o_reg_we   = 1'b0;
         o_pc_sel   = PC_PLUS4;
         o_alu_src  = 1'b0;
         o_alu_op   = ALU_ADD;
         o_wb_sel   = WB_ALU;
         o_fault    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase-list model, directed pins, random run.
module tb_multicycle_ctrl;
   import riscv_pkg::*;

   localparam int TMO = 16;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] i_instruction = '0;
   logic        i_zero = 1'b0;
   logic        i_mem_ack = 1'b0;
   logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_pc_we, o_reg_we;
   logic        o_pc_sel, o_alu_src, o_fault;
   logic [1:0]  o_alu_op, o_wb_sel;
   logic [2:0]  o_state;

   multicycle_ctrl #(.ACK_TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instruction(i_instruction),
      .i_zero(i_zero), .i_mem_ack(i_mem_ack),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_addr_sel(o_addr_sel),
      .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_reg_we(o_reg_we),
      .o_pc_sel(o_pc_sel), .o_alu_src(o_alu_src), .o_alu_op(o_alu_op),
      .o_wb_sel(o_wb_sel), .o_state(o_state), .o_fault(o_fault)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: current phase plus the phases still owed by the instruction in IR.
   state_e      m_ph = FETCH;
   state_e      m_todo[$];
   logic [31:0] m_ir = '0;
   logic [31:0] forced_ir = '0;
   bit          use_forced = 1'b0;
   int          m_wait = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [8];
      logic [31:0] r;
      ops = '{OP_IMM, OP_LOAD, OP_STORE, OP_LUI, OP_BRANCH, OP_JAL, 7'h7F, 7'h33};
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 7)];
      return r;
   endfunction

   function automatic void next_phase();
      if (m_todo.size() > 0) m_ph = m_todo.pop_front();
      else                   m_ph = FETCH;
   endfunction

   function automatic void load_phases(logic [6:0] op);
      m_todo.delete();
      case (op)
         OP_IMM, OP_LUI:    m_todo = '{DECODE, EXEC, WB};
         OP_LOAD:           m_todo = '{DECODE, EXEC, MEM, WB};
         OP_STORE:          m_todo = '{DECODE, EXEC, MEM};
         OP_BRANCH, OP_JAL: m_todo = '{DECODE, EXEC};
`ifdef MULTICYCLE_CTRL_TRAP_EN
         default:           m_todo = '{DECODE, TRAP};
`else
         default:           m_todo = '{DECODE};
`endif
      endcase
      next_phase();
   endfunction

   function automatic void model_reset();
      m_ph = FETCH;
      m_todo.delete();
      m_wait = 0;
   endfunction

   function automatic void model_step(logic ack);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      if ((m_ph == FETCH || m_ph == MEM) && !ack) begin
         m_wait++;
         if (m_wait == TMO) begin
            m_ph = TRAP;
            m_todo.delete();
            m_wait = 0;
            return;
         end
      end else m_wait = 0;
`endif
      case (m_ph)
         FETCH: if (ack) begin
            m_ir = use_forced ? forced_ir : rand_instr();
            use_forced = 1'b0;
            load_phases(m_ir[6:0]);
         end
         MEM:   if (ack) next_phase();
         TRAP:  ;
         default: next_phase();
      endcase
   endfunction

   // Packed: mem_req mem_we addr_sel ir_we pc_we reg_we pc_sel alu_src alu_op wb_sel state fault
   function automatic logic [15:0] expect_vec(state_e ph, logic [6:0] op, logic zero,
                                              logic ack, logic rstb);
      logic mreq, mwe, asel, irwe, pcwe, rwe, psel, asrc, flt;
      logic [1:0] aop, wsel;
      state_e st;
      {mreq, mwe, asel, irwe, pcwe, rwe, psel, asrc, flt} = '0;
      aop = 2'd0; wsel = 2'd0; st = ph;
      if (!rstb) st = FETCH;
      else case (ph)
         FETCH: begin
            mreq = 1'b1;
            if (ack) begin irwe = 1'b1; pcwe = 1'b1; end
         end
         EXEC: case (op)
            OP_IMM:            begin asrc = 1'b1; aop = 2'd2; end
            OP_LOAD, OP_STORE: asrc = 1'b1;
            OP_BRANCH: begin
               aop = 2'd1;
               if (zero) begin pcwe = 1'b1; psel = 1'b1; end
            end
            OP_JAL: begin pcwe = 1'b1; psel = 1'b1; rwe = 1'b1; wsel = 2'd2; end
            default: ;
         endcase
         MEM: begin mreq = 1'b1; asel = 1'b1; mwe = (op == OP_STORE); end
         WB: begin
            rwe = 1'b1;
            wsel = (op == OP_LOAD) ? 2'd1 : (op == OP_LUI) ? 2'd3 : 2'd0;
         end
         TRAP: flt = 1'b1;
         default: ;
      endcase
      return {mreq, mwe, asel, irwe, pcwe, rwe, psel, asrc, aop, wsel, st, flt};
   endfunction

   task automatic run_cycle(input logic ack, input logic zero, input logic rstb);
      logic [15:0] exp, act;
      @(posedge i_clk);
      #1;
      i_rst_n = rstb;
      i_mem_ack = ack;
      i_zero = zero;
      i_instruction = m_ir;
      @(negedge i_clk);
      exp = expect_vec(m_ph, m_ir[6:0], i_zero, i_mem_ack, i_rst_n);
      act = {o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_pc_we, o_reg_we, o_pc_sel,
             o_alu_src, o_alu_op, o_wb_sel, o_state, o_fault};
      chk($sformatf("cycle[%s op=%0h]", m_ph.name(), m_ir[6:0]), {16'h0, act}, {16'h0, exp});
      if (!i_rst_n) model_reset();
      else          model_step(i_mem_ack);
   endtask

   initial begin
      int memreq_cnt;
      logic [0:7] lw_ack;

      run_cycle(1'b0, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b0, 1'b0);
      chk("reset_state", {29'h0, o_state}, {29'h0, FETCH});
      chk("reset_req_fault", {30'h0, o_mem_req, o_fault}, 32'h0);

      // addi, zero-wait, straight after reset release
      forced_ir = 32'h00500093; use_forced = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b1);
      chk("first_req_after_reset", {31'h0, o_mem_req}, 32'h1);
      chk("addi_fetch_we", {30'h0, o_ir_we, o_pc_we}, 32'h3);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("addi_decode", {29'h0, o_state}, 32'h1);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("addi_exec", {29'h0, o_alu_src, o_alu_op}, 32'h6);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("addi_wb", {29'h0, o_reg_we, o_wb_sel}, 32'h4);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("addi_back_fetch", {29'h0, o_state}, 32'h0);

      // lw with three wait cycles in MEM: 8 cycles total, 4 cycles of data request
      forced_ir = 32'h0000A103; use_forced = 1'b1;
      lw_ack = 8'b1000_0010;
      memreq_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         run_cycle(lw_ack[c], 1'b0, 1'b1);
         if (o_mem_req && o_addr_sel) memreq_cnt++;
      end
      chk("lw_wb", {29'h0, o_reg_we, o_wb_sel}, 32'h5);
      chk("lw_mem_req_cycles", memreq_cnt, 32'd4);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("lw_total_8", {29'h0, o_state}, 32'h0);

      // beq taken and not taken
      for (int z = 1; z >= 0; z--) begin
         forced_ir = 32'h00208463; use_forced = 1'b1;
         run_cycle(1'b1, 1'b0, 1'b1);
         run_cycle(1'b0, 1'b0, 1'b1);
         run_cycle(1'b0, 1'(z), 1'b1);
         chk($sformatf("beq_exec_z%0d", z), {29'h0, o_pc_we, o_pc_sel, o_alu_op[0]},
             (z == 1) ? 32'h7 : 32'h1);
         run_cycle(1'b0, 1'b0, 1'b1);
         chk($sformatf("beq_latency_z%0d", z), {29'h0, o_state}, 32'h0);
      end

      // illegal opcode 0x7F
      forced_ir = 32'h0000007F; use_forced = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b1);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      chk("illegal_trap", {28'h0, o_state, o_fault}, {28'h0, TRAP, 1'b1});
      run_cycle(1'b0, 1'b0, 1'b0);
`else
      chk("illegal_nop", {28'h0, o_state, o_fault}, 32'h0);
`endif

      // reset mid-MEM of a sw
      forced_ir = 32'h0020A023; use_forced = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b1);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("sw_mem", {29'h0, o_mem_req, o_mem_we, o_addr_sel}, 32'h7);
      run_cycle(1'b0, 1'b0, 1'b0);
      chk("sw_reset_drop", {27'h0, o_mem_req, o_reg_we, o_state}, 32'h0);
      run_cycle(1'b0, 1'b0, 1'b1);
      chk("req_after_release", {28'h0, o_mem_req, o_state}, 32'h8);

`ifdef MULTICYCLE_CTRL_TRAP_EN
      for (int c = 0; c < TMO; c++) run_cycle(1'b0, 1'b0, 1'b1);
      chk("timeout_trap", {28'h0, o_state, o_fault}, {28'h0, TRAP, 1'b1});
      run_cycle(1'b0, 1'b0, 1'b0);
`endif

      // random traffic with occasional reset pulses
      for (int c = 0; c < 4000; c++) begin
         run_cycle($urandom_range(0, 99) < 60, 1'($urandom()), $urandom_range(0, 99) >= 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
